riscv_htif_mailbox: RTL and testbench
=====================================

# riscv_htif_mailbox

Synthesizable tohost/fromhost mailbox between the core's data-bus slave port and the host CSR handshake consumed by the host-interface (HTIF) simulation monitor. A core store to TOHOST is held and presented on `host_csr_tohost` until the host consumes it. A host write delivers a word into FROMHOST, which the core polls or takes as an interrupt. One clock domain, no combinational path from bus inputs to host outputs.

## Interface
- `XLEN`, 32: data width, 32 or 64.
- `ADDR_W`, 12: bus address width, local to the mailbox window.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `bus_req`  in  1  access request; held until `bus_ack`.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  ADDR_W  byte address.
- `bus_wdata`  in  XLEN  write data.
- `bus_rdata`  out  XLEN  read data, valid with `bus_ack`.
- `bus_ack`  out  1  one-cycle completion pulse.
- `bus_err`  out  1  with `bus_ack`: unmapped address.
- `host_csr_req`  in  1  host request; held until `host_csr_ack`.
- `host_csr_we`  in  1  1 = host writes FROMHOST, 0 = host consumes TOHOST.
- `host_csr_fromhost`  in  XLEN  host write data.
- `host_csr_ack`  out  1  one-cycle host completion pulse.
- `host_csr_tohost`  out  XLEN  current TOHOST register.
- `irq_fromhost`  out  1  level; equals FROMHOST valid flag.

## Operation
- Word offset: `OFS = log2(XLEN/8)`. Register index: `bus_addr[OFS+1:OFS]`.
- Register index 0 is TOHOST (R/W).
- Register index 1 is FROMHOST (R, read-to-clear valid; writes ignored).
- Register index 2 is STATUS:
  - bit0 is tohost_pending and is read-only.
  - bit1 is fromhost_valid and is read-only.
  - bit2 is overrun, sticky; it is cleared by a bus write with wdata[2]=1.
- Any nonzero `bus_addr[ADDR_W-1:OFS+2]`, or register index 3, is unmapped:
  - `bus_ack` with `bus_err`=1.
  - `bus_rdata` = 0.
  - No state change.
- Bus FSM states:
  - B_IDLE, with `bus_req`:
    - TOHOST write while pending → B_STALL.
    - Anything else → B_ACK.
  - B_STALL → B_ACK once pending is 0 at the start of the cycle.
  - B_ACK: pulse `bus_ack` and commit the write, then → B_IDLE.
- A TOHOST write loads the register and sets pending.
- Host FSM states: H_IDLE → H_ACK on `host_csr_req`. H_ACK pulses `host_csr_ack` and commits, then → H_IDLE. The host must drop `host_csr_req` in the cycle after the ack.
- Host consume (`we`=0) clears TOHOST to 0 and clears pending.
- Host write (`we`=1) loads FROMHOST and sets valid. If valid was already 1, it also sets overrun and the new value overwrites the old one.
- A bus read of FROMHOST returns the register and clears valid, unless a host write commits in the same cycle; then valid stays 1 and the bus returns the old value.

## Timing
- Reset values of outputs:
  - `bus_ack`, `bus_err`, `host_csr_ack`, `irq_fromhost` = 0.
  - `bus_rdata`, `host_csr_tohost` = 0.
  - Both FSMs go to IDLE; all flags are 0.
- Bus latency: `bus_ack` comes 1 cycle after `req` is sampled (B_IDLE→B_ACK). On stall it comes 1 cycle after pending is observed clear.
- Host latency: `host_csr_ack` comes 1 cycle after `req` is sampled.
- `host_csr_tohost` updates in the cycle after the B_ACK commit, and reads 0 the cycle after the host consume.
- Same-cycle host consume and stalled bus write: the consume commits first. The bus write is accepted the following cycle, so the host always sees the old value before it is cleared.
- `rst` mid-transaction aborts both FSMs, with no ack issued. Masters must reissue.

## Structure
- Shared package `riscv_mpsoc_pkg` holds:
  - register indices `HTIF_MBX_TOHOST`=0, `HTIF_MBX_FROMHOST`=1, `HTIF_MBX_STATUS`=2;
  - STATUS bit positions;
  - the enum typedefs for the bus and host FSM states.
- Single module; no sub-module. Bus and host FSMs are separate always blocks sharing the register file.

## Test plan
- Reset: hold `rst` for 3 cycles. All outputs must read 0 and STATUS must read 0.
- Pass path: bus write TOHOST=1 at addr 0x0. Required: `bus_ack` 1 cycle later, then `host_csr_tohost`=1. Host consume (req, we=0) returns ack and tohost=0.
- Back-pressure: write TOHOST=0x2A, then write TOHOST=0x54 with no host consume. The second `bus_ack` must be withheld for ≥20 cycles. After the host consume, ack arrives 2 cycles later and tohost=0x54.
- Host delivery: host writes FROMHOST=0xDEAD. Required: `irq_fromhost`=1. A bus read at addr 0x4 returns 0xDEAD and `irq_fromhost` drops the next cycle.
- Overrun: two host writes 0x1 then 0x2 with no bus read. STATUS must read 0b110 and FROMHOST must read 0x2. A bus write of STATUS=0x4 clears overrun.
- Unmapped and reset abort:
  - A read at addr 0xC returns `bus_err`=1 and rdata=0.
  - Assert `rst` during B_STALL: no ack, and tohost=0 afterwards.

Source files
------------

// File: rtl/riscv_mpsoc_pkg.sv
// Shared definitions for the MPSoC blocks.
// Holds the HTIF mailbox register map, STATUS bit positions and the
// state encodings of the mailbox bus and host FSMs.
package riscv_mpsoc_pkg;

    // Mailbox register indices (word index within the mailbox window)
    localparam logic [1:0] HTIF_MBX_TOHOST   = 2'd0;
    localparam logic [1:0] HTIF_MBX_FROMHOST = 2'd1;
    localparam logic [1:0] HTIF_MBX_STATUS   = 2'd2;

    // STATUS register bit positions
    localparam int HTIF_MBX_ST_PENDING = 0;
    localparam int HTIF_MBX_ST_VALID   = 1;
    localparam int HTIF_MBX_ST_OVERRUN = 2;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_STALL = 2'd1,
        B_ACK   = 2'd2
    } htif_bus_state_t;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_ACK  = 1'b1
    } htif_host_state_t;

endpackage

// File: rtl/riscv_htif_mailbox.sv
// tohost/fromhost mailbox between a core data-bus slave port and the
// HTIF host CSR handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus_req/we/addr/wdata  core bus request (held until bus_ack)
//   bus_rdata/ack/err   core bus response (one-cycle ack pulse)
//   host_csr_req/we/fromhost  host request (held until host_csr_ack)
//   host_csr_ack        one-cycle host completion pulse
//   host_csr_tohost     current TOHOST register
//   irq_fromhost        FROMHOST valid flag
//
// Host-side outputs are driven only from registers, so there is no
// combinational path from the bus inputs to the host.
module riscv_htif_mailbox
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN-1:0]   bus_rdata,
    output logic              bus_ack,
    output logic              bus_err,
    input  logic              host_csr_req,
    input  logic              host_csr_we,
    input  logic [XLEN-1:0]   host_csr_fromhost,
    output logic              host_csr_ack,
    output logic [XLEN-1:0]   host_csr_tohost,
    output logic              irq_fromhost
);

    localparam int OFS = $clog2(XLEN / 8);

    htif_bus_state_t  bus_state_reg, bus_state_next;
    htif_host_state_t host_state_reg, host_state_next;

    logic [XLEN-1:0] tohost_reg;
    logic [XLEN-1:0] fromhost_reg;
    logic            pending_reg;
    logic            valid_reg;
    logic            overrun_reg;

    logic [1:0]      reg_idx;
    logic            addr_unmapped;
    logic            tohost_wr_hit;
    logic            bus_commit;
    logic            host_commit;
    logic [XLEN-1:0] status_word;

    // Byte-lane bits inside a word carry no register selection.
    logic            unused_lane_bits;
    assign unused_lane_bits = ^bus_addr[OFS-1:0];

    assign reg_idx       = bus_addr[OFS+1:OFS];
    assign addr_unmapped = (|bus_addr[ADDR_W-1:OFS+2]) || (reg_idx == 2'd3);
    assign tohost_wr_hit = !addr_unmapped && bus_we && (reg_idx == HTIF_MBX_TOHOST);

    always_comb begin
        status_word                      = '0;
        status_word[HTIF_MBX_ST_PENDING] = pending_reg;
        status_word[HTIF_MBX_ST_VALID]   = valid_reg;
        status_word[HTIF_MBX_ST_OVERRUN] = overrun_reg;
    end

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state_reg <= B_IDLE;
        end else begin
            bus_state_reg <= bus_state_next;
        end
    end

    // A stalled TOHOST write only proceeds once pending has been seen
    // clear in the register, so a host consume always commits (and the
    // host sees the old value) before the new value is loaded.
    always_comb begin
        bus_state_next = bus_state_reg;
        bus_ack        = 1'b0;
        bus_err        = 1'b0;
        bus_rdata      = '0;
        bus_commit     = 1'b0;
        case (bus_state_reg)
            B_IDLE: begin
                if (bus_req) begin
                    bus_state_next = (tohost_wr_hit && pending_reg) ? B_STALL : B_ACK;
                end
            end
            B_STALL: begin
                if (!pending_reg) begin
                    bus_state_next = B_ACK;
                end
            end
            B_ACK: begin
                bus_ack        = 1'b1;
                bus_commit     = 1'b1;
                bus_err        = addr_unmapped;
                bus_state_next = B_IDLE;
                if (!addr_unmapped && !bus_we) begin
                    case (reg_idx)
                        HTIF_MBX_TOHOST:   bus_rdata = tohost_reg;
                        HTIF_MBX_FROMHOST: bus_rdata = fromhost_reg;
                        HTIF_MBX_STATUS:   bus_rdata = status_word;
                        default:           bus_rdata = '0;
                    endcase
                end
            end
            default: bus_state_next = B_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Host FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            host_state_reg <= H_IDLE;
        end else begin
            host_state_reg <= host_state_next;
        end
    end

    always_comb begin
        host_state_next = host_state_reg;
        host_csr_ack    = 1'b0;
        host_commit     = 1'b0;
        case (host_state_reg)
            H_IDLE: begin
                if (host_csr_req) begin
                    host_state_next = H_ACK;
                end
            end
            H_ACK: begin
                host_csr_ack    = 1'b1;
                host_commit     = 1'b1;
                host_state_next = H_IDLE;
            end
            default: host_state_next = H_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared register file
    // ------------------------------------------------------------------
    logic bus_wr_en, bus_rd_en, host_wr_en, host_consume;

    assign bus_wr_en    = bus_commit && bus_we && !addr_unmapped;
    assign bus_rd_en    = bus_commit && !bus_we && !addr_unmapped;
    assign host_wr_en   = host_commit && host_csr_we;
    assign host_consume = host_commit && !host_csr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_reg   <= '0;
            fromhost_reg <= '0;
            pending_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            // Consume first; a bus TOHOST write landing in the same cycle
            // is ordered after it and therefore wins.
            if (host_consume) begin
                tohost_reg  <= '0;
                pending_reg <= 1'b0;
            end
            if (bus_wr_en && (reg_idx == HTIF_MBX_TOHOST)) begin
                tohost_reg  <= bus_wdata;
                pending_reg <= 1'b1;
            end

            // A host delivery in the same cycle as a FROMHOST read keeps
            // valid set: the bus got the old word, the new one is unread.
            if (host_wr_en) begin
                fromhost_reg <= host_csr_fromhost;
                valid_reg    <= 1'b1;
            end else if (bus_rd_en && (reg_idx == HTIF_MBX_FROMHOST)) begin
                valid_reg <= 1'b0;
            end

            // Clear precedes set so a simultaneous new overrun is kept.
            if (bus_wr_en && (reg_idx == HTIF_MBX_STATUS) && bus_wdata[HTIF_MBX_ST_OVERRUN]) begin
                overrun_reg <= 1'b0;
            end
            if (host_wr_en && valid_reg) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign host_csr_tohost = tohost_reg;
    assign irq_fromhost    = valid_reg;

endmodule

// File: tb/tb_riscv_htif_mailbox.sv
module tb_riscv_htif_mailbox;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bus_req = 1'b0;
    logic              bus_we = 1'b0;
    logic [ADDR_W-1:0] bus_addr = '0;
    logic [XLEN-1:0]   bus_wdata = '0;
    logic [XLEN-1:0]   bus_rdata;
    logic              bus_ack;
    logic              bus_err;
    logic              host_csr_req = 1'b0;
    logic              host_csr_we = 1'b0;
    logic [XLEN-1:0]   host_csr_fromhost = '0;
    logic              host_csr_ack;
    logic [XLEN-1:0]   host_csr_tohost;
    logic              irq_fromhost;

    int vectors = 0;
    int miscompares = 0;

    riscv_htif_mailbox #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus_req           (bus_req),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_rdata         (bus_rdata),
        .bus_ack           (bus_ack),
        .bus_err           (bus_err),
        .host_csr_req      (host_csr_req),
        .host_csr_we       (host_csr_we),
        .host_csr_fromhost (host_csr_fromhost),
        .host_csr_ack      (host_csr_ack),
        .host_csr_tohost   (host_csr_tohost),
        .irq_fromhost      (irq_fromhost)
    );

    always #5 clk = ~clk;

    // Behavioural reference: the mailbox as five plain variables updated
    // once per completed transaction.
    logic [XLEN-1:0] m_tohost, m_from;
    logic            m_pending, m_valid, m_ovr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input logic we, input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] wd,
                            output logic [XLEN-1:0] rd, output logic err, output int lat);
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        bus_req   = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus_ack && lat < 60);
        check("bus_ack_seen", {63'd0, bus_ack}, 64'd1);
        rd  = bus_rdata;
        err = bus_err;
        tick();
        bus_req = 1'b0;
        check("bus_ack_pulse", {63'd0, bus_ack}, 64'd0);
    endtask

    task automatic host_xfer(input logic we, input logic [XLEN-1:0] d, output int lat);
        host_csr_we       = we;
        host_csr_fromhost = d;
        host_csr_req      = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!host_csr_ack && lat < 60);
        check("host_ack_seen", {63'd0, host_csr_ack}, 64'd1);
        tick();
        host_csr_req = 1'b0;
    endtask

    task automatic check_host_view(input string tag);
        check({tag, "_tohost"}, {32'd0, host_csr_tohost}, {32'd0, m_tohost});
        check({tag, "_irq"}, {63'd0, irq_fromhost}, {63'd0, m_valid});
    endtask

    initial begin
        logic [XLEN-1:0]   rd;
        logic              err;
        int                lat;
        int                n;
        logic [ADDR_W-1:0] a;
        logic [XLEN-1:0]   d;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) tick();
        check("rst_bus_ack", {63'd0, bus_ack}, 64'd0);
        check("rst_bus_err", {63'd0, bus_err}, 64'd0);
        check("rst_bus_rdata", {32'd0, bus_rdata}, 64'd0);
        check("rst_host_ack", {63'd0, host_csr_ack}, 64'd0);
        check("rst_tohost", {32'd0, host_csr_tohost}, 64'd0);
        check("rst_irq", {63'd0, irq_fromhost}, 64'd0);
        rst = 1'b0;
        tick();
        bus_xfer(1'b0, 12'h008, '0, rd, err, lat);
        check("rst_status", {32'd0, rd}, 64'd0);

        // ---------------- pass path ----------------
        bus_xfer(1'b1, 12'h000, 32'h1, rd, err, lat);
        check("pass_lat", lat, 1);
        check("pass_err", {63'd0, err}, 64'd0);
        check("pass_tohost", {32'd0, host_csr_tohost}, 64'd1);
        host_xfer(1'b0, '0, lat);
        check("consume_lat", lat, 1);
        check("consume_tohost", {32'd0, host_csr_tohost}, 64'd0);

        // ---------------- back-pressure ----------------
        bus_xfer(1'b1, 12'h000, 32'h2A, rd, err, lat);
        check("bp_first_lat", lat, 1);
        bus_we = 1'b1; bus_addr = 12'h000; bus_wdata = 32'h54; bus_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_stall_no_ack", {63'd0, bus_ack}, 64'd0);
        end
        check("bp_tohost_held", {32'd0, host_csr_tohost}, 64'h2A);
        host_csr_we = 1'b0; host_csr_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!host_csr_ack && n < 60);
        check("bp_host_ack", {63'd0, host_csr_ack}, 64'd1);
        check("bp_host_sees_old", {32'd0, host_csr_tohost}, 64'h2A);
        tick();
        host_csr_req = 1'b0;
        check("bp_cleared", {32'd0, host_csr_tohost}, 64'd0);
        check("bp_ack_not_early", {63'd0, bus_ack}, 64'd0);
        tick();
        check("bp_ack_2cyc", {63'd0, bus_ack}, 64'd1);
        tick();
        bus_req = 1'b0;
        check("bp_tohost_new", {32'd0, host_csr_tohost}, 64'h54);
        host_xfer(1'b0, '0, lat);
        check("bp_drain", {32'd0, host_csr_tohost}, 64'd0);

        // ---------------- host delivery ----------------
        host_xfer(1'b1, 32'hDEAD, lat);
        check("dlv_lat", lat, 1);
        check("dlv_irq", {63'd0, irq_fromhost}, 64'd1);
        bus_xfer(1'b0, 12'h004, '0, rd, err, lat);
        check("dlv_rdata", {32'd0, rd}, 64'hDEAD);
        check("dlv_irq_drop", {63'd0, irq_fromhost}, 64'd0);

        // ---------------- overrun ----------------
        host_xfer(1'b1, 32'h1, lat);
        host_xfer(1'b1, 32'h2, lat);
        bus_xfer(1'b0, 12'h008, '0, rd, err, lat);
        check("ovr_status", {32'd0, rd}, 64'h6);
        bus_xfer(1'b0, 12'h004, '0, rd, err, lat);
        check("ovr_from", {32'd0, rd}, 64'h2);
        bus_xfer(1'b1, 12'h008, 32'h4, rd, err, lat);
        bus_xfer(1'b0, 12'h008, '0, rd, err, lat);
        check("ovr_cleared", {32'd0, rd}, 64'h0);

        // ---------------- unmapped ----------------
        bus_xfer(1'b0, 12'h00C, '0, rd, err, lat);
        check("unmap_err", {63'd0, err}, 64'd1);
        check("unmap_rdata", {32'd0, rd}, 64'd0);
        bus_xfer(1'b1, 12'h100, 32'h77, rd, err, lat);
        check("unmap_hi_err", {63'd0, err}, 64'd1);
        check("unmap_no_write", {32'd0, host_csr_tohost}, 64'd0);

        // ---------------- reset during stall ----------------
        bus_xfer(1'b1, 12'h000, 32'h11, rd, err, lat);
        bus_we = 1'b1; bus_addr = 12'h000; bus_wdata = 32'h22; bus_req = 1'b1;
        repeat (3) begin
            tick();
            check("abort_stall", {63'd0, bus_ack}, 64'd0);
        end
        rst = 1'b1;
        bus_req = 1'b0;
        tick();
        check("abort_no_ack", {63'd0, bus_ack}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_no_ack2", {63'd0, bus_ack}, 64'd0);
        check("abort_tohost", {32'd0, host_csr_tohost}, 64'd0);
        bus_xfer(1'b0, 12'h008, '0, rd, err, lat);
        check("abort_status", {32'd0, rd}, 64'd0);

        // ---------------- randomized against the model ----------------
        m_tohost = '0; m_from = '0; m_pending = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
        for (int k = 0; k < 200; k++) begin
            d = $urandom;
            case ($urandom_range(0, 8))
                0: begin
                    if (m_pending) begin
                        host_xfer(1'b0, '0, lat);
                        m_tohost = '0; m_pending = 1'b0;
                    end
                    a = {8'd0, 2'd0, 2'($urandom_range(0, 3))};
                    bus_xfer(1'b1, a, d, rd, err, lat);
                    check("r_tohost_lat", lat, 1);
                    m_tohost = d; m_pending = 1'b1;
                end
                1: begin
                    check("r_pre_consume", {32'd0, host_csr_tohost}, {32'd0, m_tohost});
                    host_xfer(1'b0, '0, lat);
                    m_tohost = '0; m_pending = 1'b0;
                end
                2: begin
                    host_xfer(1'b1, d, lat);
                    m_ovr = m_ovr | m_valid;
                    m_from = d; m_valid = 1'b1;
                end
                3: begin
                    a = {8'd0, 2'd1, 2'($urandom_range(0, 3))};
                    bus_xfer(1'b0, a, '0, rd, err, lat);
                    check("r_from_rd", {32'd0, rd}, {32'd0, m_from});
                    m_valid = 1'b0;
                end
                4: begin
                    a = {8'd0, 2'd2, 2'($urandom_range(0, 3))};
                    bus_xfer(1'b0, a, '0, rd, err, lat);
                    check("r_status", {32'd0, rd}, {61'd0, m_ovr, m_valid, m_pending});
                end
                5: begin
                    bus_xfer(1'b1, 12'h008, d, rd, err, lat);
                    if (d[2]) m_ovr = 1'b0;
                end
                6: begin
                    bus_xfer(1'b0, 12'h000, '0, rd, err, lat);
                    check("r_tohost_rd", {32'd0, rd}, {32'd0, m_tohost});
                    check("r_tohost_err", {63'd0, err}, 64'd0);
                end
                7: begin
                    a = ADDR_W'($urandom_range(0, 4095));
                    if (a[11:4] == 8'd0 && a[3:2] != 2'd3) a = a | 12'h00C;
                    bus_xfer(1'($urandom_range(0, 1)), a, d, rd, err, lat);
                    check("r_unmap_err", {63'd0, err}, 64'd1);
                    check("r_unmap_rd", {32'd0, rd}, 64'd0);
                end
                default: begin
                    bus_xfer(1'b1, 12'h004, d, rd, err, lat);
                end
            endcase
            check_host_view("r_view");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
